// File: rtl/mu0_pkg.sv
// Shared MU0/ARMish definitions: sequencer states and opcode constants used by decode.
package mu0_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StExec1,
    StExec2,
    StHalt
  } mu0_state_e;

  localparam logic [3:0] OP_LDA = 4'h0;
  localparam logic [3:0] OP_STO = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_JMP = 4'h4;
  localparam logic [3:0] OP_JGE = 4'h5;
  localparam logic [3:0] OP_JNE = 4'h6;
  localparam logic [3:0] OP_STP = 4'h7;
  localparam logic [3:0] OP_LDI = 4'h8;
  localparam logic [3:0] OP_LSR = 4'hA;
  localparam logic [3:0] OP_ASR = 4'hB;

  localparam logic [1:0] ARMISH_PREFIX = 2'b11;

  function automatic logic is_stp(input logic [15:0] ir);
    return ir[15:12] == OP_STP;
  endfunction

endpackage

// File: rtl/mu0_retire_counter.sv
// 16-bit wrapping retired-instruction counter with count enable.
module mu0_retire_counter (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        en_i,
  output logic [15:0] count_o
);

  logic [15:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (en_i) count_d = count_q + 16'd1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) count_q <= 16'h0000;
    else         count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/mu0_sequencer.sv
// MU0 phase sequencer: FETCH/EXEC1/EXEC2 strobes, IR, skip flag, run/step/halt control.
// Optional retired-instruction counter enabled by defining MU0_SEQ_RETIRE_CNT_EN.
module mu0_sequencer
  import mu0_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        run_i,
  input  logic        step_i,
  input  logic [15:0] mem_q_i,
  input  logic        extra_i,
  input  logic        skip_set_i,
  output logic        fetch_o,
  output logic        exec1_o,
  output logic        exec2_o,
  output logic [15:0] ir_o,
  output logic        skipstatus_o,
`ifdef MU0_SEQ_RETIRE_CNT_EN
  output logic [15:0] retired_o,
`endif
  output logic        halted_o
);

  mu0_state_e  state_q, state_d;
  logic [15:0] ir_q, ir_d;
  logic        skip_q, skip_d;
  logic        step_q, step_d;
  logic        halted_q, halted_d;
  logic        fetch_q, exec1_q, exec2_q;
  logic        inst_end;

  always_comb begin
    state_d  = state_q;
    ir_d     = ir_q;
    skip_d   = skip_q;
    step_d   = step_q;
    halted_d = halted_q;
    inst_end = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (run_i) begin
          state_d = StFetch;
        end else if (step_i && !step_q) begin
          state_d = StFetch;
          step_d  = 1'b1;
        end
      end
      StFetch: begin
        state_d = StExec1;
        ir_d    = mem_q_i;
      end
      StExec1: begin
        // A skipped STP falls through as an ordinary one-exec-cycle instruction.
        if (is_stp(ir_q) && !skip_q) begin
          state_d  = StHalt;
          halted_d = 1'b1;
        end else if (extra_i) begin
          state_d = StExec2;
        end else begin
          inst_end = 1'b1;
        end
      end
      StExec2: inst_end = 1'b1;
      StHalt:  state_d = StHalt;
      default: state_d = StIdle;
    endcase

    if (inst_end) begin
      state_d = run_i ? StFetch : StIdle;
      step_d  = 1'b0;
      skip_d  = skip_set_i;
    end
  end

  // Strobes are registered from the next state so they are clean for the whole cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      ir_q     <= 16'h0000;
      skip_q   <= 1'b0;
      step_q   <= 1'b0;
      halted_q <= 1'b0;
      fetch_q  <= 1'b0;
      exec1_q  <= 1'b0;
      exec2_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      ir_q     <= ir_d;
      skip_q   <= skip_d;
      step_q   <= step_d;
      halted_q <= halted_d;
      fetch_q  <= (state_d == StFetch);
      exec1_q  <= (state_d == StExec1);
      exec2_q  <= (state_d == StExec2);
    end
  end

  assign fetch_o      = fetch_q;
  assign exec1_o      = exec1_q;
  assign exec2_o      = exec2_q;
  assign ir_o         = ir_q;
  assign skipstatus_o = skip_q;
  assign halted_o     = halted_q;

`ifdef MU0_SEQ_RETIRE_CNT_EN
  mu0_retire_counter u_retire_cnt (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .en_i    (inst_end),
    .count_o (retired_o)
  );
`endif

endmodule

// File: tb/tb_mu0_sequencer.sv
// Directed bench for mu0_sequencer; retired-count checks only when MU0_SEQ_RETIRE_CNT_EN is defined.
module tb_mu0_sequencer;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        run_i, step_i, extra_i, skip_set_i;
  logic [15:0] mem_q_i;
  logic        fetch_o, exec1_o, exec2_o, skipstatus_o, halted_o;
  logic [15:0] ir_o;
`ifdef MU0_SEQ_RETIRE_CNT_EN
  logic [15:0] retired_o;
  logic [15:0] ret_snap;
`endif

  int errors = 0;
  int checks = 0;

  mu0_sequencer dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .run_i        (run_i),
    .step_i       (step_i),
    .mem_q_i      (mem_q_i),
    .extra_i      (extra_i),
    .skip_set_i   (skip_set_i),
    .fetch_o      (fetch_o),
    .exec1_o      (exec1_o),
    .exec2_o      (exec2_o),
    .ir_o         (ir_o),
    .skipstatus_o (skipstatus_o),
`ifdef MU0_SEQ_RETIRE_CNT_EN
    .retired_o    (retired_o),
`endif
    .halted_o     (halted_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [2:0] phase();
    return {fetch_o, exec1_o, exec2_o};
  endfunction

  localparam logic [2:0] PhNone = 3'b000;
  localparam logic [2:0] PhF    = 3'b100;
  localparam logic [2:0] PhE1   = 3'b010;
  localparam logic [2:0] PhE2   = 3'b001;

  initial begin
    rst_ni = 1'b0; run_i = 1'b1; step_i = 1'b0; extra_i = 1'b0; skip_set_i = 1'b0;
    mem_q_i = 16'h8005;
    #12;
    check("rst_phase", 32'(phase()), 32'(PhNone));
    check("rst_ir", 32'(ir_o), 32'h0);
    check("rst_skip", 32'(skipstatus_o), 32'h0);
    check("rst_halted", 32'(halted_o), 32'h0);
`ifdef MU0_SEQ_RETIRE_CNT_EN
    check("rst_retired", 32'(retired_o), 32'h0);
`endif

    // LDI free-run: period 2
    @(negedge clk_i); rst_ni = 1'b1;
    tick(); check("ldi_f0", 32'(phase()), 32'(PhF));
    tick(); check("ldi_e0", 32'(phase()), 32'(PhE1));
    check("ldi_ir", 32'(ir_o), 32'h8005);
    tick(); check("ldi_f1", 32'(phase()), 32'(PhF));
    tick(); check("ldi_e1", 32'(phase()), 32'(PhE1));

    // LDA with EXTRA: period 3
    tick(); check("lda_f_pre", 32'(phase()), 32'(PhF));
    mem_q_i = 16'h0010; extra_i = 1'b1;
    tick(); check("lda_e1", 32'(phase()), 32'(PhE1));
    check("lda_ir", 32'(ir_o), 32'h0010);
    tick(); check("lda_e2", 32'(phase()), 32'(PhE2));
    tick(); check("lda_f", 32'(phase()), 32'(PhF));
`ifdef MU0_SEQ_RETIRE_CNT_EN
    ret_snap = retired_o;
`endif
    tick(); check("lda_e1b", 32'(phase()), 32'(PhE1));
    tick(); check("lda_e2b", 32'(phase()), 32'(PhE2));
    check("lda_ir_stable", 32'(ir_o), 32'h0010);

    // Skip the following STP
    skip_set_i = 1'b1; mem_q_i = 16'h7000;
    tick(); check("skip_f", 32'(phase()), 32'(PhF));
    check("skip_set", 32'(skipstatus_o), 32'h1);
`ifdef MU0_SEQ_RETIRE_CNT_EN
    check("lda_retire_inc", 32'(retired_o), 32'(ret_snap + 16'd1));
`endif
    skip_set_i = 1'b0; extra_i = 1'b0;
    tick(); check("skip_e1", 32'(phase()), 32'(PhE1));
    check("skip_ir", 32'(ir_o), 32'h7000);
    check("skip_held", 32'(skipstatus_o), 32'h1);
    tick(); check("skip_nohalt", 32'(phase()), 32'(PhF));
    check("skip_clr", 32'(skipstatus_o), 32'h0);
    check("skip_halted", 32'(halted_o), 32'h0);

    // Unskipped STP halts
    tick(); check("stp_e1", 32'(phase()), 32'(PhE1));
`ifdef MU0_SEQ_RETIRE_CNT_EN
    ret_snap = retired_o;
`endif
    tick(); check("stp_halt_ph", 32'(phase()), 32'(PhNone));
    check("stp_halted", 32'(halted_o), 32'h1);
    for (int i = 0; i < 20; i++) begin
      run_i = i[0]; step_i = i[1];
      tick();
      check("halt_ph", 32'(phase()), 32'(PhNone));
      check("halt_hold", 32'(halted_o), 32'h1);
    end
`ifdef MU0_SEQ_RETIRE_CNT_EN
    check("halt_retired", 32'(retired_o), 32'(ret_snap));
`endif
    run_i = 1'b0; step_i = 1'b0;
    rst_ni = 1'b0; #1;
    check("halt_rst_halted", 32'(halted_o), 32'h0);
    check("halt_rst_ir", 32'(ir_o), 32'h0);

    // Single-step LDA with repeated STEP pulses
    mem_q_i = 16'h0010; extra_i = 1'b1;
    @(negedge clk_i); rst_ni = 1'b1;
    tick(); check("step_idle", 32'(phase()), 32'(PhNone));
    step_i = 1'b1; tick(); step_i = 1'b0;
    check("step_f", 32'(phase()), 32'(PhF));
    step_i = 1'b1; tick(); step_i = 1'b0;
    check("step_e1", 32'(phase()), 32'(PhE1));
    step_i = 1'b1; tick(); step_i = 1'b0;
    check("step_e2", 32'(phase()), 32'(PhE2));
    tick(); check("step_idle_end", 32'(phase()), 32'(PhNone));
    tick(); check("step_idle_stay", 32'(phase()), 32'(PhNone));
`ifdef MU0_SEQ_RETIRE_CNT_EN
    check("step_retired", 32'(retired_o), 32'h1);
`endif

    // RUN dropping mid-instruction finishes it
    run_i = 1'b1; tick(); check("drop_f", 32'(phase()), 32'(PhF));
    run_i = 1'b0;
    tick(); check("drop_e1", 32'(phase()), 32'(PhE1));
    tick(); check("drop_e2", 32'(phase()), 32'(PhE2));
    tick(); check("drop_idle", 32'(phase()), 32'(PhNone));

    // Reset mid-EXEC2 with skip pending
    run_i = 1'b1;
    tick(); tick(); tick(); check("mid_e2a", 32'(phase()), 32'(PhE2));
    skip_set_i = 1'b1;
    tick(); check("mid_skip", 32'(skipstatus_o), 32'h1);
    skip_set_i = 1'b0;
    tick(); tick(); check("mid_e2b", 32'(phase()), 32'(PhE2));
    #3 rst_ni = 1'b0; #1;
    check("mid_rst_ph", 32'(phase()), 32'(PhNone));
    check("mid_rst_ir", 32'(ir_o), 32'h0);
    check("mid_rst_skip", 32'(skipstatus_o), 32'h0);
    check("mid_rst_halt", 32'(halted_o), 32'h0);
`ifdef MU0_SEQ_RETIRE_CNT_EN
    check("mid_rst_ret", 32'(retired_o), 32'h0);

    // Counter wrap
    run_i = 1'b0; mem_q_i = 16'h8005; extra_i = 1'b0;
    @(negedge clk_i); rst_ni = 1'b1;
    force dut.u_retire_cnt.count_q = 16'hFFFF;
    #1 release dut.u_retire_cnt.count_q;
    check("wrap_pre", 32'(retired_o), 32'hFFFF);
    step_i = 1'b1; tick(); step_i = 1'b0;
    tick(); tick();
    check("wrap_idle", 32'(phase()), 32'(PhNone));
    check("wrap_post", 32'(retired_o), 32'h0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
